// File: rtl/pri_issue_if.sv
// pri_issue_if: request/issue bundle for pri_issue.
//   i_set  : per-source request pulses (bit i marks source i pending)
//   i_rdy  : consumer accepts the presented request
//   o_vld  : an issued request is presented
//   o_oh   : one-hot of the presented source (zero when o_vld low)
//   o_id   : binary index of the presented source (zero when o_vld low)
//   o_pend : pending vector, excluding the presented entry
// Modports: master = producer/consumer side, slave = pri_issue.
interface pri_issue_if #(
  parameter int W    = 8,
  parameter int ID_W = $clog2(W)
);
  logic [W-1:0]    i_set;
  logic            i_rdy;
  logic            o_vld;
  logic [W-1:0]    o_oh;
  logic [ID_W-1:0] o_id;
  logic [W-1:0]    o_pend;

  modport master (
    output i_set, i_rdy,
    input  o_vld, o_oh, o_id, o_pend
  );

  modport slave (
    input  i_set, i_rdy,
    output o_vld, o_oh, o_id, o_pend
  );
endinterface

// File: rtl/pri_issue.sv
// pri_issue: collects per-source request pulses into a pending vector and
// issues one source per cycle through a single registered output stage.
// Ports:
//   clk    : single clock, all state updates on its rising edge
//   arst_n : asynchronous active-low reset (deassertion synchronous to clk)
//   bus    : pri_issue_if.slave (i_set, i_rdy in; o_vld, o_oh, o_id, o_pend out)
// Configuration macro PRI_ISSUE_RR_EN:
//   defined   -> round-robin; search starts one above the last issued id
//   undefined -> fixed priority, lowest pending index wins, no pointer state
module pri_issue #(
  parameter int W    = 8,
  parameter int ID_W = $clog2(W)
) (
  input logic        clk,
  input logic        arst_n,
  pri_issue_if.slave bus
);

  logic [W-1:0]    pend_r;
  logic            vld_r;
  logic [W-1:0]    oh_r;
  logic [ID_W-1:0] id_r;

  logic            any_s;
  logic            load_s;
  logic [ID_W-1:0] sel_id_s;
  logic [W-1:0]    sel_oh_s;
  logic [W-1:0]    clr_s;

`ifdef PRI_ISSUE_RR_EN
  logic [ID_W-1:0] ptr_r;

  // Rotating search: first pending bit at ptr+1, ptr+2, ... wrapping modulo W.
  always_comb begin
    int              cand;
    logic            found;
    logic [ID_W-1:0] idx;
    sel_id_s = '0;
    found    = 1'b0;
    cand     = 0;
    idx      = '0;
    for (int k = 1; k <= W; k++) begin
      cand     = int'(ptr_r) + k;
      // ptr+k never exceeds 2W-1, so one subtraction is enough to wrap.
      cand     = (cand >= W) ? (cand - W) : cand;
      idx      = ID_W'(cand);
      sel_id_s = (pend_r[idx] && !found) ? idx : sel_id_s;
      found    = found | pend_r[idx];
    end
  end

  // Pointer remembers the id of the most recent load; reset so index 0 is first.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr_r <= ID_W'(W - 1);
    end else if (load_s) begin
      ptr_r <= sel_id_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  // Fixed priority: walking down from the top leaves the lowest pending index.
  always_comb begin
    sel_id_s = '0;
    for (int i = W - 1; i >= 0; i--) begin
      sel_id_s = pend_r[i] ? ID_W'(i) : sel_id_s;
    end
  end
`endif

  // Load decision and the one-hot that is cleared from the pending vector.
  always_comb begin
    sel_oh_s = '0;
    any_s    = |pend_r;
    // i_rdy only matters while something is presented.
    load_s   = (!vld_r || bus.i_rdy) && any_s;
    for (int i = 0; i < W; i++) begin
      sel_oh_s[i] = any_s && (sel_id_s == ID_W'(i));
    end
    clr_s = load_s ? sel_oh_s : '0;
  end

  // Pending vector: OR-in of i_set after the clear gives set priority over
  // clear, so a source re-requested while being loaded stays pending.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pend_r <= '0;
    end else begin
      pend_r <= (pend_r & ~clr_s) | bus.i_set;
    end
  end

  // Single output stage: load, drain on accept with nothing pending, or hold.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_r <= 1'b0;
      oh_r  <= '0;
      id_r  <= '0;
    end else if (load_s) begin
      vld_r <= 1'b1;
      oh_r  <= sel_oh_s;
      id_r  <= sel_id_s;
    end else if (vld_r && bus.i_rdy) begin
      vld_r <= 1'b0;
      oh_r  <= '0;
      id_r  <= '0;
    end else begin
      vld_r <= vld_r;
      oh_r  <= oh_r;
      id_r  <= id_r;
    end
  end

  assign bus.o_vld  = vld_r;
  assign bus.o_oh   = oh_r;
  assign bus.o_id   = id_r;
  assign bus.o_pend = pend_r;

endmodule

// File: tb/tb_pri_issue.sv
// tb_pri_issue: directed stimulus with a scoreboard queue of expected issues;
// a negedge monitor pops one entry per accepted issue and checks output
// invariants every cycle. Expectations cover both PRI_ISSUE_RR_EN settings.
module tb_pri_issue;

  localparam int W = 8;

  typedef struct packed {
    logic [2:0] id;
    logic [7:0] oh;
    logic [7:0] pend;
  } exp_t;

  logic clk;
  logic arst_n;
  exp_t sb[$];
  int   n_chk;
  int   n_pass;
  logic stall_q;
  logic [2:0] prev_id;
  logic [7:0] prev_oh;

  pri_issue_if #(.W(W)) bus ();

  pri_issue #(.W(W)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] id, input logic [7:0] oh, input logic [7:0] pend);
    exp_t e;
    e.id   = id;
    e.oh   = oh;
    e.pend = pend;
    sb.push_back(e);
  endtask

  // Wait (bounded) until every expected issue has been accepted.
  task automatic wait_drain(input int budget);
    int left;
    left = budget;
    while (sb.size() != 0 && left > 0) begin
      @(negedge clk);
      #2;
      left--;
    end
    check("drain_in_time", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: per-cycle invariants, stall stability, scoreboard pop on accept.
  always @(negedge clk) begin
    exp_t e;
    if (arst_n) begin
      if (bus.o_vld) begin
        check("oh_onehot", 32'($countones(bus.o_oh)), 32'd1);
        check("oh_matches_id", 32'(bus.o_oh), 32'(8'b1 << bus.o_id));
      end else begin
        check("idle_oh_zero", 32'(bus.o_oh), 32'd0);
        check("idle_id_zero", 32'(bus.o_id), 32'd0);
      end
      if (stall_q) begin
        check("stall_id_stable", 32'(bus.o_id), 32'(prev_id));
        check("stall_oh_stable", 32'(bus.o_oh), 32'(prev_oh));
      end
      if (bus.o_vld && bus.i_rdy) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_issue: got id %0d expected no issue at %0t", bus.o_id, $time);
        end else begin
          e = sb.pop_front();
          check("sb_id", 32'(bus.o_id), 32'(e.id));
          check("sb_oh", 32'(bus.o_oh), 32'(e.oh));
          check("sb_pend", 32'(bus.o_pend), 32'(e.pend));
        end
      end
      stall_q = bus.o_vld && !bus.i_rdy;
      prev_id = bus.o_id;
      prev_oh = bus.o_oh;
    end else begin
      stall_q = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    stall_q     = 1'b0;
    prev_id     = 3'd0;
    prev_oh     = 8'd0;
    arst_n      = 1'b0;
    bus.i_set   = 8'h00;
    bus.i_rdy   = 1'b0;

    // Reset state.
    step(2);
    check("rst_vld", 32'(bus.o_vld), 32'd0);
    check("rst_oh", 32'(bus.o_oh), 32'd0);
    check("rst_id", 32'(bus.o_id), 32'd0);
    check("rst_pend", 32'(bus.o_pend), 32'd0);
    arst_n = 1'b1;
    step(1);

    // Back-to-back: 8'h81 -> id 0 then 7 (pointer starts at 7 in round-robin).
    push(3'd0, 8'h01, 8'h80);
    push(3'd7, 8'h80, 8'h00);
    bus.i_rdy = 1'b1;
    bus.i_set = 8'h81;
    step(1);
    bus.i_set = 8'h00;
    step(3);
    check("b2b_vld_drop", 32'(bus.o_vld), 32'd0);
    check("b2b_pend_zero", 32'(bus.o_pend), 32'd0);
    check("b2b_sb_empty", 32'(sb.size()), 32'd0);
    step(1);

    // Latency: set driven after edge 0, captured at edge 1, presented after edge 2.
    push(3'd0, 8'h01, 8'h00);
    bus.i_set = 8'h01;
    step(1);
    bus.i_set = 8'h00;
    check("lat_not_early", 32'(bus.o_vld), 32'd0);
    step(1);
    check("lat_vld", 32'(bus.o_vld), 32'd1);
    check("lat_id", 32'(bus.o_id), 32'd0);
    check("lat_oh", 32'(bus.o_oh), 32'h01);
    step(1);
    check("lat_one_cycle", 32'(bus.o_vld), 32'd0);
    check("lat_sb_empty", 32'(sb.size()), 32'd0);
    step(1);

    // Backpressure: id 2 held 3 cycles, re-set during the stall, then reissued.
    push(3'd2, 8'h04, 8'h04);
    push(3'd2, 8'h04, 8'h00);
    bus.i_rdy = 1'b0;
    bus.i_set = 8'h04;
    step(1);
    bus.i_set = 8'h00;
    step(1);
    check("bp_presented", 32'(bus.o_id), 32'd2);
    bus.i_set = 8'h04;
    step(1);
    bus.i_set = 8'h00;
    check("bp_held_id", 32'(bus.o_id), 32'd2);
    step(1);
    check("bp_held_vld", 32'(bus.o_vld), 32'd1);
    check("bp_held_pend", 32'(bus.o_pend), 32'h04);
    bus.i_rdy = 1'b1;
    step(1);
    check("bp_reissue_vld", 32'(bus.o_vld), 32'd1);
    check("bp_reissue_id", 32'(bus.o_id), 32'd2);
    check("bp_reissue_pend", 32'(bus.o_pend), 32'd0);
    step(1);
    check("bp_drop", 32'(bus.o_vld), 32'd0);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-traffic with P = 8'hF0 and id 0 presented.
    bus.i_rdy = 1'b0;
    bus.i_set = 8'h01;
    step(1);
    bus.i_set = 8'hF0;
    step(1);
    bus.i_set = 8'h00;
    check("mr_vld_before", 32'(bus.o_vld), 32'd1);
    check("mr_pend_before", 32'(bus.o_pend), 32'hF0);
    arst_n = 1'b0;
    #1;
    check("mr_vld_async", 32'(bus.o_vld), 32'd0);
    check("mr_oh_async", 32'(bus.o_oh), 32'd0);
    check("mr_id_async", 32'(bus.o_id), 32'd0);
    check("mr_pend_async", 32'(bus.o_pend), 32'd0);
    step(2);
    arst_n    = 1'b1;
    bus.i_rdy = 1'b1;
    step(1);
    check("mr_quiet_1", 32'(bus.o_vld), 32'd0);
    step(1);
    check("mr_quiet_2", 32'(bus.o_vld), 32'd0);
    check("mr_quiet_pend", 32'(bus.o_pend), 32'd0);

    // Fairness: all sources requesting every cycle; pointer is back at 7.
    for (int i = 0; i < 9; i++) begin
`ifdef PRI_ISSUE_RR_EN
      push(3'(i % 8), 8'b1 << (i % 8), 8'hFF);
`else
      push(3'd0, 8'h01, 8'hFF);
`endif
    end
    bus.i_set = 8'hFF;
    wait_drain(40);
    arst_n    = 1'b0;
    bus.i_set = 8'h00;
    sb.delete();
    step(2);
    arst_n = 1'b1;
    step(1);
    check("end_idle", 32'(bus.o_vld), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
